// File: rtl/serial_word_comparator_if.sv
// Handshake and result bundle between the nibble comparator stage and the
// serial word comparator.
interface serial_word_comparator_if;
  logic start;
  logic in_valid;
  logic eq_in;
  logic agb_in;
  logic alb_in;
  logic busy;
  logic done;
  logic word_eq;
  logic word_agb;
  logic word_alb;
  logic err;

  modport master (
    output start, in_valid, eq_in, agb_in, alb_in,
    input  busy, done, word_eq, word_agb, word_alb, err
  );

  modport slave (
    input  start, in_valid, eq_in, agb_in, alb_in,
    output busy, done, word_eq, word_agb, word_alb, err
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Serial multi-nibble word comparator: MSB nibble first, the first unequal
// nibble decides, and every beat is consumed to keep word framing intact.
module serial_word_comparator #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_word_comparator_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, COMPARE, DECIDED, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dagb, dagb_n, dalb, dalb_n;
  logic             weq_n, wagb_n, walb_n, err_n;
  logic [2:0]       flags;
  logic             onehot;

  assign flags  = {bus.eq_in, bus.agb_in, bus.alb_in};
  assign onehot = $onehot(flags);

  // The decision is tracked internally; word_* only change on the completion
  // edge so they stay all-zero while the word is in flight.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dagb_n  = dagb;
    dalb_n  = dalb;
    weq_n   = bus.word_eq;
    wagb_n  = bus.word_agb;
    walb_n  = bus.word_alb;
    err_n   = bus.err;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = COMPARE;
          cnt_n   = '0;
          dagb_n  = 1'b0;
          dalb_n  = 1'b0;
          weq_n   = 1'b0;
          wagb_n  = 1'b0;
          walb_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      COMPARE, DECIDED: begin
        if (bus.in_valid) begin
          cnt_n = cnt + CNT_W'(1);
          if (!onehot) err_n = 1'b1;
          if (state == COMPARE && onehot) begin
            dagb_n = bus.agb_in;
            dalb_n = bus.alb_in;
          end
          if (cnt_n == LAST) begin
            state_n = DONE;
            weq_n   = !(dagb_n || dalb_n);
            wagb_n  = dagb_n;
            walb_n  = dalb_n;
          end else if (dagb_n || dalb_n) begin
            state_n = DECIDED;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dagb         <= 1'b0;
      dalb         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.word_eq  <= 1'b0;
      bus.word_agb <= 1'b0;
      bus.word_alb <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      dagb         <= dagb_n;
      dalb         <= dalb_n;
      bus.busy     <= (state_n == COMPARE) || (state_n == DECIDED);
      bus.done     <= (state_n == DONE);
      bus.word_eq  <= weq_n;
      bus.word_agb <= wagb_n;
      bus.word_alb <= walb_n;
      bus.err      <= err_n;
    end
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator: expected word results are queued
// when a word is launched and compared when done pulses.
module tb_serial_word_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic eq;
    logic agb;
    logic alb;
    logic err;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [2:0] F_EQ  = 3'b100;
  localparam logic [2:0] F_AGB = 3'b010;
  localparam logic [2:0] F_ALB = 3'b001;

  serial_word_comparator_if bus ();

  serial_word_comparator #(.NIBBLES(4), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted beat; optionally also pulse start in the same cycle.
  task automatic beat(input logic [2:0] f, input logic st = 1'b0);
    bus.in_valid = 1'b1;
    {bus.eq_in, bus.agb_in, bus.alb_in} = f;
    bus.start = st;
    cyc();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    {bus.eq_in, bus.agb_in, bus.alb_in} = 3'b000;
  endtask

  task automatic in_flight(input string tag);
    chk({tag, "_busy"}, {3'b0, bus.busy}, 4'h1);
    chk({tag, "_res0"}, {1'b0, bus.word_eq, bus.word_agb, bus.word_alb}, 4'h0);
    chk({tag, "_nodone"}, {3'b0, bus.done}, 4'h0);
  endtask

  task automatic launch(input exp_t e);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    exp_q.push_back(e);
    chk("start_busy", {3'b0, bus.busy}, 4'h1);
    chk("start_clr", {bus.word_eq, bus.word_agb, bus.word_alb, bus.err}, 4'h0);
  endtask

  // Called right after the final beat: done must already be high.
  task automatic finish_word(input string tag);
    exp_t e;
    chk({tag, "_done"}, {3'b0, bus.done}, 4'h1);
    chk({tag, "_idle"}, {3'b0, bus.busy}, 4'h0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 4'h0, 4'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_res"}, {bus.word_eq, bus.word_agb, bus.word_alb, bus.err}, e);
    end
    cyc();
    chk({tag, "_pulse1"}, {3'b0, bus.done}, 4'h0);
    chk({tag, "_held"}, {bus.word_eq, bus.word_agb, bus.word_alb, bus.err}, e);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.eq_in = 1'b0; bus.agb_in = 1'b0; bus.alb_in = 1'b0;
    cyc(); cyc();
    chk("rst_outs", {bus.busy, bus.done, bus.err, bus.word_eq | bus.word_agb | bus.word_alb}, 4'h0);
    rst = 1'b0;
    cyc();

    // Equal word with gaps of 0 and 2 cycles
    launch('{eq:1'b1, agb:1'b0, alb:1'b0, err:1'b0});
    beat(F_EQ); in_flight("eq_b1");
    beat(F_EQ); in_flight("eq_b2");
    cyc(); cyc(); in_flight("eq_gap");
    beat(F_EQ); in_flight("eq_b3");
    beat(F_EQ);
    finish_word("eq");

    // Early decision, later opposite beats ignored (back-to-back start)
    launch('{eq:1'b0, agb:1'b1, alb:1'b0, err:1'b0});
    beat(F_AGB); in_flight("early_b1");
    beat(F_ALB); beat(F_ALB); in_flight("early_b3");
    beat(F_ALB);
    finish_word("early");

    // Late decision on the last beat
    launch('{eq:1'b0, agb:1'b0, alb:1'b1, err:1'b0});
    beat(F_EQ); beat(F_EQ); beat(F_EQ); in_flight("late_b3");
    beat(F_ALB);
    finish_word("late");

    // Malformed flags count as equal but set err
    launch('{eq:1'b1, agb:1'b0, alb:1'b0, err:1'b1});
    beat(F_EQ); beat(3'b011);
    chk("mal_err_live", {3'b0, bus.err}, 4'h1);
    beat(F_EQ); beat(F_EQ);
    finish_word("mal");

    // start mid-word ignored; launch() also checks err was cleared
    launch('{eq:1'b0, agb:1'b0, alb:1'b1, err:1'b0});
    beat(F_EQ);
    beat(F_EQ, 1'b1); in_flight("mid_start");
    beat(F_ALB); in_flight("mid_b3");
    beat(F_AGB);
    finish_word("mid");

    // start together with in_valid in IDLE: that beat is not counted
    bus.in_valid = 1'b1; {bus.eq_in, bus.agb_in, bus.alb_in} = F_AGB;
    launch('{eq:1'b1, agb:1'b0, alb:1'b0, err:1'b0});
    bus.in_valid = 1'b0; {bus.eq_in, bus.agb_in, bus.alb_in} = 3'b000;
    beat(F_EQ); beat(F_EQ); beat(F_EQ); in_flight("ign_b3");
    beat(F_EQ);
    finish_word("ign");

    // Reset after two beats aborts the word
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    beat(F_AGB); beat(F_EQ);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_outs", {bus.busy, bus.done, bus.err, bus.word_eq | bus.word_agb | bus.word_alb}, 4'h0);
    cyc();
    chk("midrst_nodone", {bus.busy, bus.done, 2'b0}, 4'h0);

    // Fresh word after reset completes normally
    launch('{eq:1'b0, agb:1'b1, alb:1'b0, err:1'b0});
    beat(F_EQ); beat(3'b111); beat(F_AGB); in_flight("post_b3");
    beat(F_EQ);
    chk("post_err", {3'b0, bus.err}, 4'h1);
    exp_q[0].err = 1'b1;
    finish_word("post");

    chk("sb_drained", 4'(exp_q.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
